// File: rtl/ram_master.sv
// ram_master: converts byte/half/word load-store requests into accesses on one
// NO_CHANGE byte-write RAM port. Stores and errors respond one cycle after
// accept; loads wait one extra cycle for RAM read data.
module ram_master #(
    parameter  int DATA_DEPTH = 1024,
    localparam int AW         = $clog2(DATA_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [31:0]   req_addr,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [31:0]   req_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_data,
    output logic          rsp_error,
    output logic          ram_en,
    output logic [3:0]    ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_di,
    input  logic [31:0]   ram_do
);

    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

    state_t      state, state_nxt;
    logic        accept;
    logic        req_err;
    logic        addr_oor;

    // Load context captured at accept and consumed in READ.
    logic [1:0]  off_p1;
    logic [1:0]  size_p1;
    logic        uns_p1;

    // Byte-lane write enables for a store of the given size at byte offset off.
    function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = 4'b0011 << off;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Replicate right-aligned store data across all lanes; the mask picks the live ones.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{data[7:0]}};
            2'b01:   d = {2{data[15:0]}};
            default: d = data;
        endcase
        return d;
    endfunction

    // Pick the addressed byte/half from the RAM word and sign- or zero-extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                                input logic [1:0] size, input logic uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        b = $signed(word[{off, 3'b000} +: 8]);
        h = $signed(off[1] ? word[31:16] : word[15:0]);
        case (size)
            2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    assign addr_oor = ({2'b00, req_addr[31:2]} >= 32'(DATA_DEPTH));
    assign req_err  = (req_size == 2'b11) ||
                      ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                      addr_oor;
    assign accept   = req_valid && req_ready;

    // State register; reset returns to IDLE at once, dropping any load in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: stores and errors go straight to RESP, loads pass through READ.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (req_err || req_write) ? RESP : READ;
            READ: state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and RAM strobes; the RAM is only touched in a legal accept cycle.
    always_comb begin
        req_ready = (state == IDLE) && !rst;
        rsp_valid = (state == RESP);
        ram_en    = 1'b0;
        ram_we    = 4'b0000;
        ram_addr  = req_addr[AW+1:2];
        ram_di    = store_lanes(req_size, req_data);
        if (accept && !req_err) begin
            ram_en = 1'b1;
            if (req_write) ram_we = store_mask(req_size, req_addr[1:0]);
        end
    end

    // Response registers: cleared on accept (error flag set as needed), filled from RAM in READ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data  <= 32'd0;
            rsp_error <= 1'b0;
        end else if (accept) begin
            rsp_data  <= 32'd0;
            rsp_error <= req_err;
        end else if (state == READ) begin
            rsp_data  <= load_extend(ram_do, off_p1, size_p1, uns_p1);
            rsp_error <= 1'b0;
        end
    end

    // Load context capture; pure data, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            off_p1  <= req_addr[1:0];
            size_p1 <= req_size;
            uns_p1  <= req_unsigned;
        end
    end

endmodule

// File: doc/ram_master.md
RAM_MASTER -- requirements
Module: ram_master

Interface
REQ-001 SHALL have parameter DATA_DEPTH, default 1024, meaning the number of 32-bit words in the attached RAM port; AW = $clog2(DATA_DEPTH).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 1 bit: a request is present.
REQ-005 SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-006 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port req_addr, input, 32 bits: byte address.
REQ-008 SHALL have port req_size, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-009 SHALL have port req_unsigned, input, 1 bit: zero-extend load data when 1.
REQ-010 SHALL have port req_data, input, 32 bits: store data, right-aligned.
REQ-011 SHALL have port rsp_valid, output, 1 bit: a response is present.
REQ-012 SHALL have port rsp_ready, input, 1 bit: the consumer accepts the response.
REQ-013 SHALL have port rsp_data, output, 32 bits: extended load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_error, output, 1 bit: the request was misaligned, illegal or out of range.
REQ-015 SHALL have ports ram_en, ram_we[3:0], ram_addr[AW-1:0] and ram_di[31:0] as outputs, and ram_do[31:0] as input, connecting to one NO_CHANGE byte-write RAM port.

Function
REQ-016 SHALL implement the FSM states IDLE, READ, RESP, with req_ready = 1 only in IDLE.
REQ-017 SHALL treat a request as accepted when req_valid && req_ready are both high.
REQ-018 SHALL flag a request as an error when req_size = 11, when a half access has addr[0] = 1, when a word access has addr[1:0] != 0, or when req_addr[31:2] >= DATA_DEPTH.
REQ-019 SHALL, on an accepted error request, assert no ram_en, load rsp_error = 1 and rsp_data = 0, and move to RESP.
REQ-020 SHALL, on an accepted legal store, drive the following combinationally in the accept cycle, then move to RESP with rsp_data = 0 and rsp_error = 0:
- ram_en = 1
- ram_addr = req_addr[AW+1:2]
- ram_we = 0001<<off for a byte, 0011<<off for a half, 1111 for a word, where off = addr[1:0]
- ram_di = {4{data[7:0]}} for a byte, {2{data[15:0]}} for a half, data for a word
REQ-021 SHALL, on an accepted legal load, drive ram_en = 1, ram_we = 0 and ram_addr in the accept cycle, register off, size and unsigned, and move to READ.
REQ-022 SHALL, in READ, select the addressed byte or half from ram_do, sign-extend it (zero-extend if unsigned), register the result into rsp_data with rsp_error = 0, and move to RESP.
REQ-023 SHALL, in RESP, hold rsp_valid = 1 and keep rsp_data and rsp_error stable until rsp_ready is high, then move to IDLE.
REQ-024 SHALL, in the RESP exit cycle, not accept a new request; req_ready rises the following cycle.
REQ-025 SHALL drive ram_en = 0 and ram_we = 0 in READ, in RESP, and in IDLE with no accepted request.
REQ-026 SHALL give a latency from accept to rsp_valid of 1 cycle for stores and errors, and 2 cycles for loads.
REQ-027 SHALL allow a minimum request spacing of 2 cycles (store or error) or 3 cycles (load) when rsp_ready is held at 1.

Reset
REQ-028 SHALL, while rst is high, immediately force state = IDLE, rsp_valid = 0, rsp_data = 0 and rsp_error = 0.
REQ-029 SHALL hold ram_en = 0 and ram_we = 0 during reset.
REQ-030 SHALL discard a load that is in READ or RESP when rst is asserted, with no response after reset is released.

Verification
REQ-031 SHALL cover: store word 0xDEADBEEF at 0x10, then load word at 0x10 -> ram_we = 1111 and ram_addr = 4 in the store accept cycle, and rsp_data = 0xDEADBEEF two cycles after the load accept.
REQ-032 SHALL cover: store byte 0x80 at 0x13, then load byte signed and load byte unsigned at 0x13 -> ram_we = 1000 and ram_di = 0x80808080, then rsp_data = 0xFFFFFF80 and 0x00000080.
REQ-033 SHALL cover: load half at 0x01, load word at 0x02, size 11, and address 4*DATA_DEPTH -> rsp_error = 1, rsp_data = 0, and ram_en never asserted.
REQ-034 SHALL cover: rsp_ready held low for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_error stable, req_ready = 0 throughout.
REQ-035 SHALL cover: rst asserted in READ after a load accept -> rsp_valid = 0 in the same cycle, and no response after reset is released.
REQ-036 SHALL cover: back-to-back stores with req_valid and rsp_ready held at 1 -> accepts spaced exactly 2 cycles apart.
